// File: rtl/tennis_pkg.sv
// Shared tennis definitions: court FSM states, side encodings and default court size.
package tennis_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_A = 3'd1,
    SERVE_B = 3'd2,
    TO_A    = 3'd3,
    TO_B    = 3'd4
  } court_state_t;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  localparam int DEFAULT_COURT_LEN = 8;

endpackage

// File: rtl/ball_court_step_timer.sv
// Ball step timer: counts down the current step length and pulses tick on the last cycle.
// Holds the shrinking step-length register when BALL_SPEEDUP_EN is defined.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic reload,
  input  logic enable,
`ifdef BALL_SPEEDUP_EN
  input  logic speedup,
`endif
  output logic tick
);

  localparam int CNT_W = $clog2(STEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] STEP_LEN = CNT_W'(STEP_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] step_len;
  logic [CNT_W-1:0] load_len;

`ifdef BALL_SPEEDUP_EN
  logic [CNT_W-1:0] next_len;

  assign next_len = (step_len > CNT_W'(1)) ? step_len - CNT_W'(1) : step_len;
  // A speed-up reload starts the new flight at the already-shortened length.
  assign load_len = speedup ? next_len : step_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_len <= STEP_LEN;
    end else if (clear) begin
      step_len <= STEP_LEN;
    end else if (reload && speedup) begin
      step_len <= next_len;
    end
  end
`else
  assign step_len = STEP_LEN;
  assign load_len = STEP_LEN;
`endif

  assign tick = enable && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= load_len;
    end else if (enable) begin
      cnt <= tick ? step_len : cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ball_court.sv
// Court-side ball owner: walks a one-hot ball between players A and B, drives hit zones, flags misses.
// Define BALL_SPEEDUP_EN to shorten the step length by one on each in-flight return.
module ball_court
  import tennis_pkg::*;
#(
  parameter int COURT_LEN   = DEFAULT_COURT_LEN,
  parameter int STEP_CYCLES = 4,
  parameter int HIT_ZONE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_game,
  input  logic                 return_a,
  input  logic                 return_b,
  output logic                 hittable_a,
  output logic                 hittable_b,
  output logic                 miss_a,
  output logic                 miss_b,
  output logic [COURT_LEN-1:0] ball_pos,
  output logic                 in_play
);

  localparam int POS_W = $clog2(COURT_LEN);
  localparam logic [POS_W-1:0] LAST = POS_W'(COURT_LEN - 1);

  court_state_t     state;
  logic [POS_W-1:0] pos;
  logic             tick;
  logic             ret_ok;
  logic             serve_ok;
  logic             at_end;
  logic             miss_now;
  logic             tmr_clear;
  logic             tmr_enable;

  function automatic logic [COURT_LEN-1:0] onehot(input logic [POS_W-1:0] p);
    logic [COURT_LEN-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic zone_a(input logic [POS_W-1:0] p);
    return p <= POS_W'(HIT_ZONE - 1);
  endfunction

  function automatic logic zone_b(input logic [POS_W-1:0] p);
    return p >= POS_W'(COURT_LEN - HIT_ZONE);
  endfunction

  // Only the player the ball is approaching can return it, and only inside their zone.
  always_comb begin
    ret_ok     = 1'b0;
    serve_ok   = 1'b0;
    at_end     = 1'b0;
    tmr_enable = 1'b0;
    case (state)
      SERVE_A: serve_ok = return_a;
      SERVE_B: serve_ok = return_b;
      TO_B: begin
        ret_ok     = return_b && hittable_b;
        at_end     = (pos == LAST);
        tmr_enable = 1'b1;
      end
      TO_A: begin
        ret_ok     = return_a && hittable_a;
        at_end     = (pos == '0);
        tmr_enable = 1'b1;
      end
      default: ;
    endcase
    miss_now  = tick && at_end && !ret_ok;
    tmr_clear = !start_game || miss_now;
  end

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .reload  (ret_ok || serve_ok),
    .enable  (tmr_enable),
`ifdef BALL_SPEEDUP_EN
    .speedup (ret_ok),
`endif
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pos        <= '0;
      ball_pos   <= '0;
      hittable_a <= 1'b0;
      hittable_b <= 1'b0;
      miss_a     <= 1'b0;
      miss_b     <= 1'b0;
      in_play    <= 1'b0;
    end else begin
      miss_a <= 1'b0;
      miss_b <= 1'b0;
      if (!start_game) begin
        state      <= IDLE;
        pos        <= '0;
        ball_pos   <= '0;
        hittable_a <= 1'b0;
        hittable_b <= 1'b0;
        in_play    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SERVE_A;
            pos        <= '0;
            ball_pos   <= onehot('0);
            hittable_a <= 1'b1;
            hittable_b <= 1'b0;
          end
          SERVE_A: if (return_a) begin
            state      <= TO_B;
            in_play    <= 1'b1;
            hittable_a <= 1'b0;
            hittable_b <= zone_b(pos);
          end
          SERVE_B: if (return_b) begin
            state      <= TO_A;
            in_play    <= 1'b1;
            hittable_b <= 1'b0;
            hittable_a <= zone_a(pos);
          end
          TO_B: begin
            if (ret_ok) begin
              state      <= TO_A;
              hittable_b <= 1'b0;
              hittable_a <= zone_a(pos);
            end else if (tick) begin
              if (pos == LAST) begin
                state      <= SERVE_B;
                miss_b     <= 1'b1;
                in_play    <= 1'b0;
                hittable_b <= 1'b1;
              end else begin
                pos        <= pos + POS_W'(1);
                ball_pos   <= onehot(pos + POS_W'(1));
                hittable_b <= zone_b(pos + POS_W'(1));
              end
            end
          end
          TO_A: begin
            if (ret_ok) begin
              state      <= TO_B;
              hittable_a <= 1'b0;
              hittable_b <= zone_b(pos);
            end else if (tick) begin
              if (pos == '0) begin
                state      <= SERVE_A;
                miss_a     <= 1'b1;
                in_play    <= 1'b0;
                hittable_a <= 1'b1;
              end else begin
                pos        <= pos - POS_W'(1);
                ball_pos   <= onehot(pos - POS_W'(1));
                hittable_a <= zone_a(pos - POS_W'(1));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_court.sv
// Directed bench for ball_court (8 positions, 4-cycle steps, 2-position hit zones).
// Expected step length is tracked locally so the same vectors cover the BALL_SPEEDUP_EN build.
module tb_ball_court;

  localparam int STEP = 4;

  logic       clk;
  logic       rst;
  logic       start_game;
  logic       return_a;
  logic       return_b;
  logic       hittable_a;
  logic       hittable_b;
  logic       miss_a;
  logic       miss_b;
  logic [7:0] ball_pos;
  logic       in_play;

  int checks   = 0;
  int failures = 0;
  int sl       = STEP;

  ball_court #(
    .COURT_LEN   (8),
    .STEP_CYCLES (STEP),
    .HIT_ZONE    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .return_a   (return_a),
    .return_b   (return_b),
    .hittable_a (hittable_a),
    .hittable_b (hittable_b),
    .miss_a     (miss_a),
    .miss_b     (miss_b),
    .ball_pos   (ball_pos),
    .in_play    (in_play)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ball must hold one cycle short of a full step, then move exactly on the step.
  task automatic hop(input logic [7:0] prev, input logic [7:0] nxt, input string tag);
    step(sl - 1);
    check({tag, "_hold"}, ball_pos, prev);
    step(1);
    check(tag, ball_pos, nxt);
  endtask

  task automatic flight_return();
`ifdef BALL_SPEEDUP_EN
    if (sl > 1) sl--;
`endif
  endtask

  initial begin
    rst = 1'b0; start_game = 1'b0; return_a = 1'b0; return_b = 1'b0;
    step(2);
    check("rst_ball", ball_pos, 8'h00);
    check("rst_hit", {hittable_a, hittable_b}, 2'b00);
    check("rst_miss", {miss_a, miss_b}, 2'b00);
    check("rst_play", in_play, 1'b0);
    rst = 1'b1;
    step(1);
    check("idle_ball", ball_pos, 8'h00);

    start_game = 1'b1;
    step(1);
    check("serve_a_hit", {hittable_a, hittable_b}, 2'b10);
    check("serve_a_ball", ball_pos, 8'h01);
    check("serve_a_play", in_play, 1'b0);

    return_a = 1'b1; step(1); return_a = 1'b0;
    check("launch_play", in_play, 1'b1);
    check("launch_hit", {hittable_a, hittable_b}, 2'b00);
    check("launch_ball", ball_pos, 8'h01);
    hop(8'h01, 8'h02, "tob_1");
    hop(8'h02, 8'h04, "tob_2");
    hop(8'h04, 8'h08, "tob_3");
    hop(8'h08, 8'h10, "tob_4");
    return_b = 1'b1; step(1); return_b = 1'b0;
    check("ign_b_play", in_play, 1'b1);
    step(sl - 2);
    check("ign_b_hold", ball_pos, 8'h10);
    step(1);
    check("tob_5", ball_pos, 8'h20);
    check("tob_5_hitb", hittable_b, 1'b0);
    hop(8'h20, 8'h40, "tob_6");
    check("tob_6_hitb", hittable_b, 1'b1);
    hop(8'h40, 8'h80, "tob_7");
    step(sl - 1);
    check("pre_miss_b", miss_b, 1'b0);
    step(1);
    check("miss_b_pulse", miss_b, 1'b1);
    check("serve_b_hit", {hittable_a, hittable_b}, 2'b01);
    check("serve_b_ball", ball_pos, 8'h80);
    check("serve_b_play", in_play, 1'b0);
    sl = STEP;
    step(1);
    check("miss_b_once", miss_b, 1'b0);
    check("serve_b_hold", ball_pos, 8'h80);

    return_b = 1'b1; step(1); return_b = 1'b0;
    check("serve_b_go", in_play, 1'b1);
    check("serve_b_hitb", hittable_b, 1'b0);
    hop(8'h80, 8'h40, "toa_6");
    hop(8'h40, 8'h20, "toa_5");
    hop(8'h20, 8'h10, "toa_4");
    hop(8'h10, 8'h08, "toa_3");
    hop(8'h08, 8'h04, "toa_2");
    check("toa_2_hita", hittable_a, 1'b0);
    hop(8'h04, 8'h02, "toa_1");
    check("toa_1_hita", hittable_a, 1'b1);

    return_a = 1'b1; step(1); return_a = 1'b0; flight_return();
    check("ret_a_ball", ball_pos, 8'h02);
    check("ret_a_hit", {hittable_a, hittable_b}, 2'b00);
    hop(8'h02, 8'h04, "r1_2");
    hop(8'h04, 8'h08, "r1_3");
    hop(8'h08, 8'h10, "r1_4");
    hop(8'h10, 8'h20, "r1_5");
    hop(8'h20, 8'h40, "r1_6");
    check("r1_6_hitb", hittable_b, 1'b1);

    return_b = 1'b1; step(1); return_b = 1'b0; flight_return();
    check("ret_b_ball", ball_pos, 8'h40);
    check("ret_b_nomiss", miss_b, 1'b0);
    check("ret_b_hitb", hittable_b, 1'b0);
    hop(8'h40, 8'h20, "r2_5");
    hop(8'h20, 8'h10, "r2_4");
    hop(8'h10, 8'h08, "r2_3");
    hop(8'h08, 8'h04, "r2_2");
    hop(8'h04, 8'h02, "r2_1");
    hop(8'h02, 8'h01, "r2_0");

    step(sl - 1);
    return_a = 1'b1; return_b = 1'b1; step(1); return_a = 1'b0; return_b = 1'b0;
    flight_return();
    check("term_a_nomiss", miss_a, 1'b0);
    check("term_a_ball", ball_pos, 8'h01);
    check("term_a_play", in_play, 1'b1);
    return_a = 1'b1; step(1); return_a = 1'b0;
    step(sl - 1);
    check("stray_a_ign", ball_pos, 8'h02);
    hop(8'h02, 8'h04, "r3_2");
    hop(8'h04, 8'h08, "r3_3");
    hop(8'h08, 8'h10, "r3_4");
    hop(8'h10, 8'h20, "r3_5");
    hop(8'h20, 8'h40, "r3_6");
    hop(8'h40, 8'h80, "r3_7");

    step(sl - 1);
    return_b = 1'b1; step(1); return_b = 1'b0; flight_return();
    check("term_b_nomiss", miss_b, 1'b0);
    check("term_b_ball", ball_pos, 8'h80);
    check("term_b_play", in_play, 1'b1);
    hop(8'h80, 8'h40, "r4_6");
    hop(8'h40, 8'h20, "r4_5");
    hop(8'h20, 8'h10, "r4_4");
    hop(8'h10, 8'h08, "r4_3");
    hop(8'h08, 8'h04, "r4_2");
    hop(8'h04, 8'h02, "r4_1");
    hop(8'h02, 8'h01, "r4_0");
    step(sl - 1);
    check("pre_miss_a", miss_a, 1'b0);
    step(1);
    check("miss_a_pulse", miss_a, 1'b1);
    check("serve_a2_hit", {hittable_a, hittable_b}, 2'b10);
    check("serve_a2_play", in_play, 1'b0);
    sl = STEP;

    return_a = 1'b1; step(1); return_a = 1'b0;
    hop(8'h01, 8'h02, "s2_1");
    hop(8'h02, 8'h04, "s2_2");
    step(1);
    start_game = 1'b0; step(1);
    check("drop_ball", ball_pos, 8'h00);
    check("drop_hit", {hittable_a, hittable_b}, 2'b00);
    check("drop_play", in_play, 1'b0);

    start_game = 1'b1; step(1);
    check("restart_hita", hittable_a, 1'b1);
    return_a = 1'b1; step(1); return_a = 1'b0;
    step(2);
    #2 rst = 1'b0;
    #1;
    check("arst_ball", ball_pos, 8'h00);
    check("arst_play", in_play, 1'b0);
    check("arst_hit", {hittable_a, hittable_b}, 2'b00);
    step(1);
    rst = 1'b1;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
